reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth is 2**ADDR_W entries.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-005 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port ready  output  1  high when the block accepts writes and returns stored data.
REQ-008 The block SHALL have port wen0  input  1  write enable, port 0.
REQ-009 The block SHALL have port waddr0  input  ADDR_W  write address, port 0.
REQ-010 The block SHALL have port wdata0  input  DATA_W  write data, port 0.
REQ-011 The block SHALL have ports wen1, waddr1 and wdata1 with the same widths and meanings for write port 1.
REQ-012 The block SHALL have port raddr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-013 The block SHALL have port rdata  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].

Function
REQ-014 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-015 In CLEAR, a clear counter SHALL write zero to entry[counter] each cycle, counting 0 up to 2**ADDR_W-1.
REQ-016 The FSM SHALL go from CLEAR to RUN on the edge that clears the last entry; ready SHALL rise on the following cycle.
REQ-017 Clearing SHALL therefore take exactly 2**ADDR_W cycles after rst deasserts.
REQ-018 In CLEAR, wen0 and wen1 SHALL be ignored, and every rdata lane SHALL read as zero.
REQ-019 In RUN, a write port with wen high SHALL update entry[waddr] on the rising edge.
REQ-020 If both ports write the same address in one cycle, port 1 SHALL win.
REQ-021 Writes to different addresses in the same cycle SHALL both take effect.
REQ-022 Reads SHALL be combinational: rdata lane k = entry[raddr lane k], with zero cycles of latency.
REQ-023 With ZERO_REG=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 regardless of bypass.
REQ-024 The FSM SHALL never leave RUN except through rst.

Reset
REQ-025 Asserting rst SHALL, asynchronously, force: state to CLEAR, clear counter to 0, ready to 0.
REQ-026 rst asserted mid-clear or mid-operation SHALL restart the full clear sequence from entry 0 after deassertion.
REQ-027 While rst is high, writes SHALL have no effect, and rdata SHALL read zero.

Configuration
REQ-028 Macro RF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-029 With RF_BYPASS_EN defined, in RUN, a read lane whose address matches an enabled write in the same cycle SHALL return that write's data; port 1 wins if both write ports match; address 0 is excluded when ZERO_REG=1.
REQ-030 Without RF_BYPASS_EN, a read lane SHALL return the stored value, with new data visible on the cycle after the write edge.

Verification
REQ-031 The bench SHALL cover: deassert rst, defaults -> ready low for 32 cycles, high on the 33rd; all 32 entries read 0.
REQ-032 The bench SHALL cover: in RUN, wen0=1, waddr0=5, wdata0=0xDEADBEEF, then raddr lane0=5 the next cycle -> rdata lane0=0xDEADBEEF.
REQ-033 The bench SHALL cover: wen0/wen1 both to address 7 with 0x11111111 and 0x22222222 -> entry 7 reads 0x22222222.
REQ-034 The bench SHALL cover: write 0xFFFFFFFF to address 0 -> lane reads 0 (ZERO_REG=1).
REQ-035 The bench SHALL cover: same-cycle write 0xA5A5A5A5 to address 3 with raddr=3 -> with RF_BYPASS_EN, rdata=0xA5A5A5A5 that cycle; without it, the old value that cycle and 0xA5A5A5A5 the next.
REQ-036 The bench SHALL cover: pulse rst at clear count 10 -> ready low for a further full 32 cycles; previously written entries read 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, NUM_RD combinational read ports and a
// post-reset clear sequence. Define RF_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic                     wen0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     wen1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam logic [0:0]        ST_CLEAR = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST     = '1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic run;
    logic we0;
    logic we1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = (state_q == ST_RUN);
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

    // Effective write strobes already exclude the hardwired zero entry.
    assign run = (state_q == ST_RUN) && !rst;
    assign we0 = run && wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign we1 = run && wen1 && !((ZERO_REG != 0) && (waddr1 == '0));

    // Port 1 is applied last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (we0) begin
                    mem_q[waddr0] <= wdata0;
                end
                if (we1) begin
                    mem_q[waddr1] <= wdata1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd_lane;

            assign ra = raddr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_lane = '0;
                if (run && !((ZERO_REG != 0) && (ra == '0))) begin
                    rd_lane = mem_q[ra];
`ifdef RF_BYPASS_EN
                    if (we0 && (waddr0 == ra)) begin
                        rd_lane = wdata0;
                    end
                    if (we1 && (waddr1 == ra)) begin
                        rd_lane = wdata1;
                    end
`endif
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd_lane;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp at default parameters; expectations
// for same-cycle reads follow RF_BYPASS_EN.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk    (clk),
        .rst    (rst),
        .ready  (ready),
        .wen0   (wen0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .wen1   (wen1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .raddr  (raddr),
        .rdata  (rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    task automatic idle_writes();
        wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
    endtask

    // Walk n clear edges; ready must stay low until edge 33, lane 0 reads 0 throughout.
    task automatic clear_steps(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            step();
            check_val($sformatf("%s_ready_e%0d", tag, i), {31'd0, ready}, {31'd0, (i == 33)});
            if (i <= 32) begin
                check_val($sformatf("%s_rd0_e%0d", tag, i), rdata[31:0], 32'h0);
            end
        end
    endtask

    logic [31:0] exp_same;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_writes();
        raddr = '0;
        step();
        step();
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        set_rd(5'd1, 5'd31);
        check_val("rst_rd0", rdata[31:0], 32'h0);

        // Initial clear after reset release
        rst = 1'b0;
        clear_steps("clr", 33);
        for (int a = 0; a < 32; a++) begin
            set_rd(a[4:0], 5'(31 - a));
            check_val($sformatf("init_rd0_a%0d", a), rdata[31:0], 32'h0);
            check_val($sformatf("init_rd1_a%0d", 31 - a), rdata[63:32], 32'h0);
        end

        // Single write then read next cycle
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        step();
        idle_writes();
        set_rd(5'd5, 5'd0);
        check_val("wr5_rd", rdata[31:0], 32'hDEADBEEF);

        // Collision: port 1 wins
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        step();
        idle_writes();
        set_rd(5'd7, 5'd5);
        check_val("coll7_rd0", rdata[31:0], 32'h22222222);
        check_val("coll7_rd1", rdata[63:32], 32'hDEADBEEF);

        // Distinct addresses, both writes land
        wen0 = 1'b1; waddr0 = 5'd9;  wdata0 = 32'h00000009;
        wen1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h0000000A;
        step();
        idle_writes();
        set_rd(5'd9, 5'd10);
        check_val("dual_rd9", rdata[31:0], 32'h00000009);
        check_val("dual_rd10", rdata[63:32], 32'h0000000A);

        // Hardwired zero entry, including during the write cycle
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        set_rd(5'd0, 5'd0);
        check_val("zero_same", rdata[31:0], 32'h0);
        step();
        idle_writes();
        set_rd(5'd0, 5'd0);
        check_val("zero_after", rdata[31:0], 32'h0);
        check_val("zero_after_l1", rdata[63:32], 32'h0);

        // Same-cycle read of a write target
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12345678;
        step();
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
        set_rd(5'd9, 5'd3);
`ifdef RF_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'h12345678;
`endif
        check_val("byp_same_l1", rdata[63:32], exp_same);
        check_val("byp_other_l0", rdata[31:0], 32'h00000009);
        step();
        idle_writes();
        #1;
        check_val("byp_next_l1", rdata[63:32], 32'hA5A5A5A5);

        // Asynchronous reset in RUN; writes while reset is held are dropped
        set_rd(5'd5, 5'd7);
        check_val("pre_rst_rd5", rdata[31:0], 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        check_val("async_ready", {31'd0, ready}, 32'd0);
        check_val("async_rd0", rdata[31:0], 32'h0);
        check_val("async_rd1", rdata[63:32], 32'h0);
        wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hCAFEF00D;
        step();
        idle_writes();
        rst = 1'b0;
        clear_steps("mid", 10);

        // Reset pulse at clear count 10 restarts the full sequence
        rst = 1'b1;
        #2;
        check_val("pulse_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        clear_steps("reclr", 33);
        set_rd(5'd5, 5'd7);
        check_val("reclr_rd5", rdata[31:0], 32'h0);
        check_val("reclr_rd7", rdata[63:32], 32'h0);
        set_rd(5'd3, 5'd12);
        check_val("reclr_rd3", rdata[31:0], 32'h0);
        check_val("reclr_rd12", rdata[63:32], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
